timer_dev: RTL and testbench

Programmable down-counting timer that is the responder on the CPU's processor-bridge bus (PrAddr/PrWD/PrWe/PrRD) and the source of one hardware interrupt line. The bridge decodes the timer's address window and forwards word address bits [3:2], write enable and write data; the timer returns read data combinationally and drives IRQ into the CPU's HWInt[2]. It provides a one-shot mode and an auto-reload mode, with a maskable interrupt.

---
 rtl/timer_dev.sv | 113 +++++++++++
 tb/tb_timer_dev.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/timer_dev.sv
// rtl/timer_dev.sv - programmable down-counting timer with one-shot/auto-reload modes and maskable IRQ
module timer_dev (
    input  logic        Clk,
    input  logic        Reset,
    input  logic [1:0]  Addr,
    input  logic        WE,
    input  logic [31:0] DIN,
    output logic [31:0] DOUT,
    output logic        IRQ
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        CNT  = 2'd2,
        INT  = 2'd3
    } state_t;

    localparam logic [1:0] ADDR_CTRL   = 2'd0;
    localparam logic [1:0] ADDR_PRESET = 2'd1;
    localparam logic [1:0] ADDR_COUNT  = 2'd2;
    localparam logic [1:0] MODE_RELOAD = 2'b01;

    state_t      state;
    logic        enable;
    logic [1:0]  mode;
    logic        im;
    logic [31:0] preset;
    logic [31:0] count;
    logic        irq_flag;

    logic        ctrl_wr;
    logic        preset_wr;

    assign ctrl_wr   = WE && (Addr == ADDR_CTRL);
    assign preset_wr = WE && (Addr == ADDR_PRESET);

    // Interrupt is only visible to the CPU when unmasked
    assign IRQ = im & irq_flag;

    // Read mux; COUNT and the unused slot are never written from the bus
    always_comb begin
        DOUT = 32'd0;
        case (Addr)
            ADDR_CTRL:   DOUT = {28'd0, im, mode, enable};
            ADDR_PRESET: DOUT = preset;
            ADDR_COUNT:  DOUT = count;
            default:     DOUT = 32'd0;
        endcase
    end

    // Register file and timer FSM; later assignments in the FSM override the
    // bus write where the flag must not be lost, and the bus overrides the
    // one-shot self-disable
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state    <= IDLE;
            enable   <= 1'b0;
            mode     <= 2'b00;
            im       <= 1'b0;
            preset   <= 32'd0;
            count    <= 32'd0;
            irq_flag <= 1'b0;
        end else begin
            if (preset_wr) begin
                preset <= DIN;
            end
            if (ctrl_wr) begin
                enable   <= DIN[0];
                mode     <= DIN[2:1];
                im       <= DIN[3];
                irq_flag <= 1'b0;
            end

            case (state)
                IDLE: begin
                    if (enable) begin
                        state <= LOAD;
                    end
                end
                LOAD: begin
                    count <= preset;
                    state <= CNT;
                end
                CNT: begin
                    if (!enable) begin
                        state <= IDLE;
                    end else if (count > 32'd1) begin
                        count <= count - 32'd1;
                    end else begin
                        count    <= 32'd0;
                        irq_flag <= 1'b1;
                        state    <= INT;
                    end
                end
                INT: begin
                    if (mode == MODE_RELOAD) begin
                        irq_flag <= 1'b0;
                        state    <= enable ? LOAD : IDLE;
                    end else begin
                        // One-shot: flag persists until software writes CTRL
                        if (!ctrl_wr) begin
                            enable <= 1'b0;
                        end
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_timer_dev.sv
// tb/tb_timer_dev.sv - directed table-driven bench for timer_dev
module tb_timer_dev;

    logic        Clk;
    logic        Reset;
    logic [1:0]  Addr;
    logic        WE;
    logic [31:0] DIN;
    logic [31:0] DOUT;
    logic        IRQ;
    logic        clk_run;

    int checks;
    int errors;

    typedef struct {
        logic        we;
        logic [1:0]  addr;
        logic [31:0] din;
        logic [1:0]  raddr;
        logic [31:0] exp_dout;
        logic        exp_irq;
        string       tag;
    } vec_t;

    vec_t vecs[$];

    timer_dev dut (
        .Clk   (Clk),
        .Reset (Reset),
        .Addr  (Addr),
        .WE    (WE),
        .DIN   (DIN),
        .DOUT  (DOUT),
        .IRQ   (IRQ)
    );

    initial Clk = 1'b0;
    always #5 if (clk_run) Clk = ~Clk;

    function automatic void add(input logic we, input logic [1:0] a, input logic [31:0] d,
                                input logic [1:0] ra, input logic [31:0] ed, input logic ei,
                                input string tag);
        vec_t v;
        v.we = we; v.addr = a; v.din = d; v.raddr = ra;
        v.exp_dout = ed; v.exp_irq = ei; v.tag = tag;
        vecs.push_back(v);
    endfunction

    task automatic check(input string name, input int idx, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s[%0d]: got 0x%08h expected 0x%08h", name, idx, got, exp);
        end
    endtask

    // One clock edge: present a (possibly null) bus write, then select the read address
    task automatic step(input logic we, input logic [1:0] a, input logic [31:0] d, input logic [1:0] ra);
        @(negedge Clk);
        WE = we; Addr = a; DIN = d;
        @(posedge Clk);
        #1;
        WE = 1'b0; Addr = ra;
        #1;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        clk_run = 1'b0;
        WE = 1'b0; Addr = 2'd0; DIN = 32'd0;
        Reset = 1'b1;
        #2;
        for (int a = 0; a < 4; a++) begin
            Addr = 2'(a);
            #1;
            check("reset_dout", a, DOUT, 32'd0);
            check("reset_irq", a, {31'd0, IRQ}, 32'd0);
        end
        clk_run = 1'b1;
        repeat (2) @(posedge Clk);
        @(negedge Clk);
        Reset = 1'b0;

        // CTRL width, read-only COUNT, unused slot
        add(1, 2'd0, 32'hFFFF_FFFF, 2'd0, 32'h0000_000F, 0, "ctrl_mask");
        add(1, 2'd0, 32'h0,         2'd0, 32'h0,         0, "ctrl_clr");
        add(0, 2'd0, 32'h0,         2'd2, 32'h0,         0, "settle");
        add(0, 2'd0, 32'h0,         2'd2, 32'h0,         0, "settle");
        add(1, 2'd2, 32'h1234,      2'd2, 32'h0,         0, "count_ro");
        add(1, 2'd3, 32'hDEAD,      2'd3, 32'h0,         0, "addr3");
        // One-shot, PRESET=5
        add(1, 2'd1, 32'd5, 2'd1, 32'd5, 0, "os_preset");
        add(1, 2'd0, 32'h9, 2'd0, 32'h9, 0, "os_e0");
        add(0, 2'd0, 32'h0, 2'd2, 32'd0, 0, "os_e1");
        add(0, 2'd0, 32'h0, 2'd2, 32'd5, 0, "os_e2");
        add(0, 2'd0, 32'h0, 2'd2, 32'd4, 0, "os_e3");
        add(0, 2'd0, 32'h0, 2'd2, 32'd3, 0, "os_e4");
        add(0, 2'd0, 32'h0, 2'd2, 32'd2, 0, "os_e5");
        add(0, 2'd0, 32'h0, 2'd2, 32'd1, 0, "os_e6");
        add(0, 2'd0, 32'h0, 2'd2, 32'd0, 1, "os_e7");
        add(0, 2'd0, 32'h0, 2'd0, 32'h8, 1, "os_e8");
        add(0, 2'd0, 32'h0, 2'd0, 32'h8, 1, "os_hold");
        add(1, 2'd0, 32'h8, 2'd0, 32'h8, 0, "os_ack");
        // Auto-reload, PRESET=3: pulses after e5 and e10; disable lands in LOAD
        add(1, 2'd1, 32'd3, 2'd1, 32'd3, 0, "ar_preset");
        add(1, 2'd0, 32'hB, 2'd0, 32'hB, 0, "ar_e0");
        add(0, 2'd0, 32'h0, 2'd2, 32'd0, 0, "ar_e1");
        add(0, 2'd0, 32'h0, 2'd2, 32'd3, 0, "ar_e2");
        add(0, 2'd0, 32'h0, 2'd2, 32'd2, 0, "ar_e3");
        add(0, 2'd0, 32'h0, 2'd2, 32'd1, 0, "ar_e4");
        add(0, 2'd0, 32'h0, 2'd2, 32'd0, 1, "ar_e5");
        add(0, 2'd0, 32'h0, 2'd2, 32'd0, 0, "ar_e6");
        add(0, 2'd0, 32'h0, 2'd2, 32'd3, 0, "ar_e7");
        add(0, 2'd0, 32'h0, 2'd2, 32'd2, 0, "ar_e8");
        add(0, 2'd0, 32'h0, 2'd2, 32'd1, 0, "ar_e9");
        add(0, 2'd0, 32'h0, 2'd2, 32'd0, 1, "ar_e10");
        add(1, 2'd0, 32'h0, 2'd0, 32'h0, 0, "ar_dis");
        add(0, 2'd0, 32'h0, 2'd2, 32'd3, 0, "ar_load_done");
        add(0, 2'd0, 32'h0, 2'd2, 32'd3, 0, "ar_idle");
        add(0, 2'd0, 32'h0, 2'd2, 32'd3, 0, "ar_idle2");
        // Mid-run PRESET change, then disable during CNT
        add(1, 2'd1, 32'd10, 2'd1, 32'd10, 0, "mr_preset");
        add(1, 2'd0, 32'hB,  2'd0, 32'hB,  0, "mr_e0");
        add(0, 2'd0, 32'h0,  2'd2, 32'd3,  0, "mr_e1");
        add(0, 2'd0, 32'h0,  2'd2, 32'd10, 0, "mr_e2");
        add(0, 2'd0, 32'h0,  2'd2, 32'd9,  0, "mr_e3");
        add(0, 2'd0, 32'h0,  2'd2, 32'd8,  0, "mr_e4");
        add(0, 2'd0, 32'h0,  2'd2, 32'd7,  0, "mr_e5");
        add(0, 2'd0, 32'h0,  2'd2, 32'd6,  0, "mr_e6");
        add(1, 2'd1, 32'd2,  2'd2, 32'd5,  0, "mr_newpre");
        add(0, 2'd0, 32'h0,  2'd2, 32'd4,  0, "mr_e8");
        add(0, 2'd0, 32'h0,  2'd2, 32'd3,  0, "mr_e9");
        add(0, 2'd0, 32'h0,  2'd2, 32'd2,  0, "mr_e10");
        add(0, 2'd0, 32'h0,  2'd2, 32'd1,  0, "mr_e11");
        add(0, 2'd0, 32'h0,  2'd2, 32'd0,  1, "mr_e12");
        add(0, 2'd0, 32'h0,  2'd2, 32'd0,  0, "mr_e13");
        add(0, 2'd0, 32'h0,  2'd2, 32'd2,  0, "mr_e14");
        add(0, 2'd0, 32'h0,  2'd2, 32'd1,  0, "mr_e15");
        add(0, 2'd0, 32'h0,  2'd2, 32'd0,  1, "mr_e16");
        add(0, 2'd0, 32'h0,  2'd2, 32'd0,  0, "mr_e17");
        add(0, 2'd0, 32'h0,  2'd2, 32'd2,  0, "mr_e18");
        add(1, 2'd0, 32'h8,  2'd2, 32'd1,  0, "mr_dis");
        add(0, 2'd0, 32'h0,  2'd2, 32'd1,  0, "mr_freeze");
        add(0, 2'd0, 32'h0,  2'd2, 32'd1,  0, "mr_freeze2");
        add(0, 2'd0, 32'h0,  2'd0, 32'h8,  0, "mr_ctrl");
        // Set-wins and bus-wins collisions, PRESET=0
        add(1, 2'd1, 32'd0, 2'd1, 32'd0, 0, "col_preset");
        add(1, 2'd0, 32'h9, 2'd0, 32'h9, 0, "col_e0");
        add(0, 2'd0, 32'h0, 2'd2, 32'd1, 0, "col_e1");
        add(0, 2'd0, 32'h0, 2'd2, 32'd0, 0, "col_e2");
        add(1, 2'd0, 32'h9, 2'd0, 32'h9, 1, "col_set_wins");
        add(1, 2'd0, 32'h9, 2'd0, 32'h9, 0, "col_bus_wins");
        add(0, 2'd0, 32'h0, 2'd2, 32'd0, 0, "col_e5");
        add(0, 2'd0, 32'h0, 2'd2, 32'd0, 0, "col_e6");
        add(0, 2'd0, 32'h0, 2'd2, 32'd0, 1, "col_e7");
        add(1, 2'd0, 32'h0, 2'd0, 32'h0, 0, "col_ack");

        for (int i = 0; i < vecs.size(); i++) begin
            step(vecs[i].we, vecs[i].addr, vecs[i].din, vecs[i].raddr);
            check({vecs[i].tag, "_dout"}, i, DOUT, vecs[i].exp_dout);
            check({vecs[i].tag, "_irq"}, i, {31'd0, IRQ}, {31'd0, vecs[i].exp_irq});
        end

        // Masked interrupt: flag sets with IM=0, then a CTRL write clears it
        step(1, 2'd0, 32'h1, 2'd0);
        step(0, 2'd0, 32'h0, 2'd2);
        step(0, 2'd0, 32'h0, 2'd2);
        step(0, 2'd0, 32'h0, 2'd2);
        check("mask_flag", 0, {31'd0, dut.irq_flag}, 32'd1);
        check("mask_irq", 0, {31'd0, IRQ}, 32'd0);
        step(0, 2'd0, 32'h0, 2'd0);
        check("mask_en_clr", 0, DOUT, 32'h0);
        step(1, 2'd0, 32'h8, 2'd0);
        check("mask_ctrl", 0, DOUT, 32'h8);
        check("mask_irq", 1, {31'd0, IRQ}, 32'd0);
        step(0, 2'd0, 32'h0, 2'd0);
        check("mask_irq", 2, {31'd0, IRQ}, 32'd0);

        // Asynchronous reset in the middle of a count
        step(1, 2'd1, 32'd100, 2'd1);
        step(1, 2'd0, 32'h9, 2'd2);
        for (int i = 0; i < 5; i++) step(0, 2'd0, 32'h0, 2'd2);
        check("ar_running", 0, DOUT, 32'd97);
        @(posedge Clk);
        #3;
        Reset = 1'b1;
        #1;
        check("async_count", 0, DOUT, 32'd0);
        check("async_irq", 0, {31'd0, IRQ}, 32'd0);
        Addr = 2'd0;
        #1;
        check("async_ctrl", 0, DOUT, 32'd0);
        repeat (2) @(posedge Clk);
        @(negedge Clk);
        Reset = 1'b0;
        for (int i = 0; i < 3; i++) step(0, 2'd0, 32'h0, 2'd0);
        check("post_ctrl", 0, DOUT, 32'd0);
        Addr = 2'd2;
        #1;
        check("post_count", 0, DOUT, 32'd0);
        Addr = 2'd1;
        #1;
        check("post_preset", 0, DOUT, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
